// File: rtl/mem_handshake_ram.sv
// mem_handshake_ram: byte-addressed, big-endian RAM answering the control unit's
// MOV/RW strobes with a four-phase MOV/MOC handshake and configurable wait states.
// Halfword/word accesses that break alignment are flagged, never performed.
// Optional feature macro: MEM_SIGNED_LOAD_EN adds a Signed input that makes
// byte/halfword reads sign-extend instead of zero-extend.

module mem_handshake_ram #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MOV,
  input  logic                  RW,
  input  logic [1:0]            Type,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
`ifdef MEM_SIGNED_LOAD_EN
  input  logic                  Signed,
`endif
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  Misaligned
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Right-justify a big-endian read; b0 is the byte at the request address.
  function automatic logic [31:0] load_extend(input logic [1:0] ty, input logic sgn,
                                              input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] r;
    case (ty)
      2'b00:   r = {{24{sgn & b0[7]}}, b0};
      2'b01:   r = {{16{sgn & b0[7]}}, b0, b1};
      default: r = {b0, b1, b2, b3};
    endcase
    return r;
  endfunction

  // Value reported on DataOut for a completed write: the stored bits, right-justified.
  function automatic logic [31:0] store_echo(input logic [1:0] ty, input logic [31:0] d);
    logic [31:0] r;
    case (ty)
      2'b00:   r = {24'h0, d[7:0]};
      2'b01:   r = {16'h0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Halfword needs an even address, word (and type 11) a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] ty, input logic [1:0] a_lsb);
    logic r;
    case (ty)
      2'b00:   r = 1'b0;
      2'b01:   r = a_lsb[0];
      default: r = (a_lsb != 2'b00);
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  moc_q, moc_d;
  logic                  mis_q, mis_d;
  logic [31:0]           dout_q, dout_d;

  // Request captured in IDLE; later input changes do not affect it.
  logic                  rw_q, rw_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  sgn_q, sgn_d;

  logic                  req_signed;
  logic                  mem_we;
  logic                  req_misaligned;
  logic [ADDR_WIDTH-1:0] addr_p1, addr_p2, addr_p3;
  logic [31:0]           rd_data;

  logic [7:0]            mem [DEPTH];

`ifdef MEM_SIGNED_LOAD_EN
  assign req_signed = Signed;
`else
  assign req_signed = 1'b0;
`endif

  assign addr_p1        = addr_q + ADDR_WIDTH'(1);
  assign addr_p2        = addr_q + ADDR_WIDTH'(2);
  assign addr_p3        = addr_q + ADDR_WIDTH'(3);
  assign req_misaligned = is_misaligned(type_q, addr_q[1:0]);
  assign rd_data        = load_extend(type_q, sgn_q, mem[addr_q], mem[addr_p1],
                                      mem[addr_p2], mem[addr_p3]);

  // Next-state, request latch and completion decode for the handshake FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moc_d   = moc_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sgn_d   = sgn_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MOV) begin
          rw_d    = RW;
          type_d  = Type;
          addr_d  = Address;
          wdata_d = DataIn;
          sgn_d   = req_signed;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!MOV) begin
          // Control unit withdrew the request: nothing is written, MOC never rises.
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          mis_d   = req_misaligned;
          state_d = S_ACK;
          if (req_misaligned) begin
            dout_d = 32'h0;
          end else if (rw_q) begin
            dout_d = rd_data;
          end else begin
            dout_d = store_echo(type_q, wdata_q);
            mem_we = ~Reset;
          end
        end
      end
      S_ACK: begin
        // Hold until MOV drops; DataOut keeps the last transfer's value.
        if (!MOV) begin
          moc_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and output registers; the latched request needs no reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      moc_q   <= 1'b0;
      mis_q   <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
    end
    rw_q    <= rw_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    sgn_q   <= sgn_d;
  end

  // Big-endian store on the completing edge; untouched bytes keep their contents.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      case (type_q)
        2'b00: mem[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem[addr_q]  <= wdata_q[15:8];
          mem[addr_p1] <= wdata_q[7:0];
        end
        default: begin
          mem[addr_q]  <= wdata_q[31:24];
          mem[addr_p1] <= wdata_q[23:16];
          mem[addr_p2] <= wdata_q[15:8];
          mem[addr_p3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign DataOut    = dout_q;
  assign MOC        = moc_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// tb_mem_handshake_ram: directed table, handshake/abort/reset sequences and
// randomized accesses compared against a byte-array model of the RAM.

module tb_mem_handshake_ram;

  localparam int AW    = 9;
  localparam int WS    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_SIGNED_LOAD_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          MOV;
  logic          RW;
  logic [1:0]    Type;
  logic [AW-1:0] Address;
  logic [31:0]   DataIn;
`ifdef MEM_SIGNED_LOAD_EN
  logic          Signed;
`endif
  logic [31:0]   DataOut;
  logic          MOC;
  logic          Misaligned;

  int nchecks = 0;
  int nerr    = 0;

  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic        rw;
    logic [1:0]  ty;
    logic [8:0]  a;
    logic [31:0] d;
    logic        sg;
    logic [31:0] exp_d;
    logic        exp_mis;
  } vec_t;

  vec_t tbl [23];

  mem_handshake_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .MOV(MOV),
    .RW(RW),
    .Type(Type),
    .Address(Address),
    .DataIn(DataIn),
`ifdef MEM_SIGNED_LOAD_EN
    .Signed(Signed),
`endif
    .DataOut(DataOut),
    .MOC(MOC),
    .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: a transfer of n bytes at a, big-endian, straight from the byte array.
  function automatic void model_access(input logic rw, input logic [1:0] ty, input int a,
                                       input logic [31:0] d, input logic sg,
                                       output logic [31:0] exp_d, output logic exp_mis);
    int n;
    longint v;
    longint m;
    n = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    m = longint'(1) << (8 * n);
    exp_mis = (a % n) != 0;
    exp_d = 32'h0;
    if (exp_mis) return;
    if (rw) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[a + i]);
      if (SGN_EN && sg && n < 4 && v >= m / 2) v = v - m;
      exp_d = 32'(v);
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(longint'(d) >> (8 * (n - 1 - i)));
      exp_d = 32'(longint'(d) % m);
    end
  endfunction

  // Waits for MOC with a bound; lat counts edges after the edge that sampled MOV.
  task automatic wait_moc(output int lat);
    lat = 0;
    do begin
      @(posedge Clk);
      lat++;
      #1;
    end while (!MOC && lat < 40);
  endtask

  // Full four-phase transfer; inputs are scrambled after the latch edge.
  task automatic access(input logic rw, input logic [1:0] ty, input logic [8:0] a,
                        input logic [31:0] d, input logic sg,
                        output logic [31:0] dout, output logic mis, output int lat);
    @(negedge Clk);
    MOV = 1'b1; RW = rw; Type = ty; Address = a; DataIn = d;
`ifdef MEM_SIGNED_LOAD_EN
    Signed = sg;
`endif
    @(posedge Clk);
    #2;
    RW = 1'($urandom); Type = 2'($urandom); Address = 9'($urandom); DataIn = $urandom;
`ifdef MEM_SIGNED_LOAD_EN
    Signed = 1'($urandom);
`endif
    wait_moc(lat);
    dout = DataOut;
    mis  = Misaligned;
    @(negedge Clk);
    MOV = 1'b0;
    @(posedge Clk);
    #1;
    chk("release MOC", 32'(MOC), 32'h0);
    chk("release Misaligned", 32'(Misaligned), 32'h0);
    chk("release DataOut hold", DataOut, dout);
  endtask

  task automatic run_check(input string tag, input logic rw, input logic [1:0] ty,
                           input logic [8:0] a, input logic [31:0] d, input logic sg,
                           input logic [31:0] exp_d, input logic exp_mis);
    logic [31:0] dout;
    logic        mis;
    int          lat;
    access(rw, ty, a, d, sg, dout, mis, lat);
    chk({tag, " data"}, dout, exp_d);
    chk({tag, " misaligned"}, 32'(mis), 32'(exp_mis));
    chk({tag, " latency"}, 32'(lat), 32'(WS + 1));
  endtask

  initial begin
    logic [31:0] expd;
    logic        expm;
    logic [31:0] wd;
    int          lat;
    int          n;
    int          a;

    // Memory is pre-filled with byte[i] = i[7:0] ^ 8'h5A before the table runs.
    tbl[0]  = '{1'b0, 2'b10, 9'h004, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 9'h004, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 9'h005, 32'h0,        1'b0, 32'h000000AD, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 9'h006, 32'hFFFFFF11, 1'b0, 32'h00000011, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 9'h004, 32'h0,        1'b0, 32'hDEAD11EF, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 9'h003, 32'h00001234, 1'b0, 32'h00000000, 1'b1};
    tbl[6]  = '{1'b1, 2'b10, 9'h000, 32'h0,        1'b0, 32'h5A5B5859, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 9'h004, 32'h0,        1'b0, 32'hDEAD11EF, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 9'h004, 32'h0,        1'b0, 32'h0000DEAD, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 9'h006, 32'h0,        1'b0, 32'h000011EF, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 9'h007, 32'h0,        1'b0, 32'h000000EF, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 9'h004, 32'h0,        1'b0, 32'hDEAD11EF, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 9'h002, 32'h0,        1'b0, 32'h00000000, 1'b1};
    tbl[13] = '{1'b0, 2'b01, 9'h008, 32'h9999ABCD, 1'b0, 32'h0000ABCD, 1'b0};
    tbl[14] = '{1'b1, 2'b10, 9'h008, 32'h0,        1'b0, 32'hABCD5051, 1'b0};
    tbl[15] = '{1'b1, 2'b01, 9'h005, 32'h0,        1'b0, 32'h00000000, 1'b1};
    tbl[16] = '{1'b0, 2'b10, 9'h00A, 32'h55555555, 1'b0, 32'h00000000, 1'b1};
    tbl[17] = '{1'b1, 2'b10, 9'h008, 32'h0,        1'b0, 32'hABCD5051, 1'b0};
    tbl[18] = '{1'b0, 2'b10, 9'h1FC, 32'h01020304, 1'b0, 32'h01020304, 1'b0};
    tbl[19] = '{1'b1, 2'b00, 9'h1FF, 32'h0,        1'b0, 32'h00000004, 1'b0};
    tbl[20] = '{1'b1, 2'b01, 9'h1FE, 32'h0,        1'b0, 32'h00000304, 1'b0};
    tbl[21] = '{1'b0, 2'b00, 9'h020, 32'h00000080, 1'b0, 32'h00000080, 1'b0};
    tbl[22] = '{1'b1, 2'b00, 9'h020, 32'h0,        1'b0, 32'h00000080, 1'b0};

    Reset = 1'b1; MOV = 1'b0; RW = 1'b0; Type = 2'b00; Address = '0; DataIn = '0;
`ifdef MEM_SIGNED_LOAD_EN
    Signed = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk("reset MOC", 32'(MOC), 32'h0);
    chk("reset DataOut", DataOut, 32'h0);
    chk("reset Misaligned", 32'(Misaligned), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // Fill every byte with a known pattern through word writes.
    for (int i = 0; i < DEPTH; i += 4) begin
      wd = {8'(i) ^ 8'h5A, 8'(i + 1) ^ 8'h5A, 8'(i + 2) ^ 8'h5A, 8'(i + 3) ^ 8'h5A};
      model_access(1'b0, 2'b10, i, wd, 1'b0, expd, expm);
      run_check($sformatf("fill%0d", i), 1'b0, 2'b10, 9'(i), wd, 1'b0, expd, expm);
    end

    for (int i = 0; i < 23; i++) begin
      model_access(tbl[i].rw, tbl[i].ty, int'(tbl[i].a), tbl[i].d, tbl[i].sg, expd, expm);
      run_check($sformatf("vec%0d", i), tbl[i].rw, tbl[i].ty, tbl[i].a, tbl[i].d,
                tbl[i].sg, tbl[i].exp_d, tbl[i].exp_mis);
    end

    // Handshake: MOV held high past MOC must not start a second access.
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b1; Type = 2'b10; Address = 9'h004;
    @(posedge Clk);
    wait_moc(lat);
    chk("hs latency", 32'(lat), 32'(WS + 1));
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      RW = 1'b0; Type = 2'b10; Address = 9'h004; DataIn = 32'h0;
      @(posedge Clk);
      #1;
      chk($sformatf("hs hold MOC %0d", k), 32'(MOC), 32'h1);
      chk($sformatf("hs hold DataOut %0d", k), DataOut, 32'hDEAD11EF);
    end
    @(negedge Clk);
    MOV = 1'b0;
    @(posedge Clk);
    #1;
    chk("hs drop MOC", 32'(MOC), 32'h0);
    chk("hs drop DataOut", DataOut, 32'hDEAD11EF);
    run_check("hs reread", 1'b1, 2'b10, 9'h004, 32'h0, 1'b0, 32'hDEAD11EF, 1'b0);

    // Abort: MOV withdrawn one cycle after the request.
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 9'h010; DataIn = 32'hCAFEF00D;
    @(posedge Clk);
    @(negedge Clk);
    MOV = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("abort MOC %0d", k), 32'(MOC), 32'h0);
    end
    run_check("abort reread", 1'b1, 2'b10, 9'h010, 32'h0, 1'b0, 32'h4A4B4849, 1'b0);

    // Reset landing on the edge that would complete a write.
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 9'h014; DataIn = 32'h12345678;
    @(posedge Clk);
    repeat (WS) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst busy MOC", 32'(MOC), 32'h0);
    chk("rst busy DataOut", DataOut, 32'h0);
    chk("rst busy Misaligned", 32'(Misaligned), 32'h0);
    @(negedge Clk);
    Reset = 1'b0; MOV = 1'b0;
    run_check("rst reread", 1'b1, 2'b10, 9'h014, 32'h0, 1'b0, 32'h4E4F4C4D, 1'b0);

`ifdef MEM_SIGNED_LOAD_EN
    run_check("sgn byte s1", 1'b1, 2'b00, 9'h020, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    run_check("sgn byte s0", 1'b1, 2'b00, 9'h020, 32'h0, 1'b0, 32'h00000080, 1'b0);
    model_access(1'b0, 2'b01, 32'h022, 32'h00008001, 1'b0, expd, expm);
    run_check("sgn half wr", 1'b0, 2'b01, 9'h022, 32'h00008001, 1'b0, 32'h00008001, 1'b0);
    run_check("sgn half s1", 1'b1, 2'b01, 9'h022, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
`endif

    // Randomized accesses against the byte-array model.
    for (int i = 0; i < 200; i++) begin
      logic        rw;
      logic [1:0]  ty;
      logic        sg;
      rw = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      n  = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
      a  = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      wd = $urandom;
      model_access(rw, ty, a, wd, sg, expd, expm);
      run_check($sformatf("rnd%0d", i), rw, ty, 9'(a), wd, sg, expd, expm);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
